flag_unit: RTL and testbench
============================

# flag_unit

Clocked 8086 FLAGS register and instruction-boundary event sequencer. Merges the six arithmetic flags from the ALU status word, flag-control instructions (CLC/STC/CMC/CLD/STD/CLI/STI) and SAHF/POPF loads into the architectural FLAGS word. It also evaluates Jcc conditions for the branch path and raises single-step trap and maskable-interrupt requests at instruction boundaries.

## Interface
- WORD_SIZE, 16, FLAGS and data width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  apply ALU status this cycle
- alu_status  in  16  ALU status encoding: [12]OF [8]SF [7]ZF [6]AF [5]PF [4]CF
- alu_mask  in  6  per-flag write enable {OF,SF,ZF,AF,PF,CF}
- flag_op_valid  in  1  execute flag_op this cycle
- flag_op  in  3  0 NOP, 1 CLC, 2 STC, 3 CMC, 4 CLD, 5 STD, 6 CLI, 7 STI
- load_valid  in  1  load flags from load_data
- load_sel  in  1  0 POPF (full word), 1 SAHF (low byte)
- load_data  in  16  source word
- instr_done  in  1  one-cycle pulse at each instruction boundary
- intr_req  in  1  level maskable interrupt request
- int_enter  in  1  pulse: interrupt/trap entry, clears IF and TF
- cond_code  in  4  Jcc low nibble
- flags  out  16  FLAGS: [11]OF [10]DF [9]IF [8]TF [7]SF [6]ZF [4]AF [2]PF [0]CF, other bits 0
- cond_true  out  1  cond_code satisfied by current flags
- trap_take  out  1  one-cycle pulse: single-step trap
- intr_take  out  1  one-cycle pulse: accept INTR

## Operation
- Write priority within a cycle, per bit: int_enter (IF, TF := 0) > load > flag_op > ALU. Lower sources still write bits that higher ones leave untouched.
- ALU write: for each set alu_mask bit, copy the matching alu_status bit to its FLAGS position. Unmasked bits hold.
- POPF: flags := load_data & 16'h0FD5. SAHF: flags[7:0] := load_data[7:0] & 8'hD5, and flags[15:8] hold.
- CMC inverts CF. The remaining ops set or clear CF, DF or IF.
- Reserved bits (15:12, 5, 3, 1) always read 0.
- cond_true is combinational from registered flags. Codes 0 O, 1 NO, 2 B(CF), 3 AE, 4 E(ZF), 5 NE, 6 BE(CF|ZF), 7 A, 8 S, 9 NS, A P, B NP, C L(SF^OF), D GE, E LE(ZF|(SF^OF)), F G. Odd codes are the complement of the preceding even code.
- Boundary sequencer state:
  - shadow: set by an executed STI; cleared at the next instr_done.
  - tf_start: TF captured at each instr_done.
- At instr_done, using register values before any same-cycle update:
  - trap = tf_start.
  - intr = IF & intr_req & ~shadow & ~trap.
- trap has priority over intr. An intr lost to trap or shadow is re-evaluated at the next boundary, since intr_req is level.

## Timing
- All flag writes take effect at the next rising edge, so flags shows them one cycle after the valid.
- trap_take and intr_take are registered: high for exactly the cycle after the instr_done cycle, never both.
- Trap occurs after the instruction following the one that set TF. An update completing before boundary k yields trap_take after boundary k+1.
- A loaded TF=1 must settle at least one cycle before instr_done.
- Reset (asynchronous, any time, including mid-boundary): flags, shadow, tf_start, trap_take and intr_take all go to 0. Pending pulses are dropped.

## Structure
- Package flag_pkg holds:
  - FLAGS bit-position constants and the alu_status position constants.
  - flag_op and load_sel encodings.
  - Jcc cond_code constants.
  - Reserved masks 16'h0FD5 and 8'hD5.
- One sub-module, flag_cond: purely combinational cond_code/flags to cond_true evaluator, reused by the branch unit.

## Test plan
- After reset, ALU write with alu_status=16'h1090 and alu_mask=6'h3F -> flags=16'h0841. Then alu_mask=6'h3E with alu_status=0 -> flags=16'h0001 (CF held).
- POPF load_data=16'hFFFF -> flags=16'h0FD5. SAHF load_data=16'h0000 -> flags=16'h0F00. CMC -> 16'h0F01.
- Same cycle: load_valid POPF 16'h0000 plus flag_op STC plus int_enter -> flags=16'h0000 (load wins over STC; IF and TF 0).
- flags with SF=1, OF=0 -> cond C true, D false, E true. With ZF=1, CF=0 -> cond 6 true, 7 false, 4 true.
- IF=0, intr_req=1, STI then instr_done -> no intr_take (shadow). Next instr_done -> intr_take high one cycle later for exactly 1 cycle.
- POPF 16'h0100, then instr_done#1 -> no trap_take. instr_done#2 with intr_req=1 and IF=1 -> trap_take only. int_enter -> TF=0, IF=0. Assert reset_n low mid-pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants for the 8086 FLAGS unit: bit positions, op/load encodings,
// Jcc condition codes and the architectural reserved-bit masks.
package flag_pkg;

  localparam int WORD_SIZE = 16;

  // FLAGS word bit positions
  localparam int FL_CF = 0;
  localparam int FL_PF = 2;
  localparam int FL_AF = 4;
  localparam int FL_ZF = 6;
  localparam int FL_SF = 7;
  localparam int FL_TF = 8;
  localparam int FL_IF = 9;
  localparam int FL_DF = 10;
  localparam int FL_OF = 11;

  // ALU status word bit positions
  localparam int ST_CF = 4;
  localparam int ST_PF = 5;
  localparam int ST_AF = 6;
  localparam int ST_ZF = 7;
  localparam int ST_SF = 8;
  localparam int ST_OF = 12;

  // alu_mask bit positions, mask is {OF,SF,ZF,AF,PF,CF}
  localparam int AM_CF = 0;
  localparam int AM_PF = 1;
  localparam int AM_AF = 2;
  localparam int AM_ZF = 3;
  localparam int AM_SF = 4;
  localparam int AM_OF = 5;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_CLC = 3'd1,
    OP_STC = 3'd2,
    OP_CMC = 3'd3,
    OP_CLD = 3'd4,
    OP_STD = 3'd5,
    OP_CLI = 3'd6,
    OP_STI = 3'd7
  } flag_op_e;

  typedef enum logic {
    LOAD_POPF = 1'b0,
    LOAD_SAHF = 1'b1
  } load_sel_e;

  localparam logic [3:0] CC_O  = 4'h0;
  localparam logic [3:0] CC_NO = 4'h1;
  localparam logic [3:0] CC_B  = 4'h2;
  localparam logic [3:0] CC_AE = 4'h3;
  localparam logic [3:0] CC_E  = 4'h4;
  localparam logic [3:0] CC_NE = 4'h5;
  localparam logic [3:0] CC_BE = 4'h6;
  localparam logic [3:0] CC_A  = 4'h7;
  localparam logic [3:0] CC_S  = 4'h8;
  localparam logic [3:0] CC_NS = 4'h9;
  localparam logic [3:0] CC_P  = 4'hA;
  localparam logic [3:0] CC_NP = 4'hB;
  localparam logic [3:0] CC_L  = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_LE = 4'hE;
  localparam logic [3:0] CC_G  = 4'hF;

  localparam logic [15:0] FLAGS_MASK = 16'h0FD5;
  localparam logic [7:0]  SAHF_MASK  = 8'hD5;

endpackage

// File: rtl/flag_unit_if.sv
// Control/status bundle between the execution pipeline and the FLAGS unit.
// master = pipeline side, slave = flag_unit.
interface flag_unit_if;
  import flag_pkg::*;

  logic                 alu_valid;
  logic [WORD_SIZE-1:0] alu_status;
  logic [5:0]           alu_mask;
  logic                 flag_op_valid;
  logic [2:0]           flag_op;
  logic                 load_valid;
  logic                 load_sel;
  logic [WORD_SIZE-1:0] load_data;
  logic                 instr_done;
  logic                 intr_req;
  logic                 int_enter;
  logic [3:0]           cond_code;
  logic [WORD_SIZE-1:0] flags;
  logic                 cond_true;
  logic                 trap_take;
  logic                 intr_take;

  modport master (
    output alu_valid, alu_status, alu_mask, flag_op_valid, flag_op,
           load_valid, load_sel, load_data, instr_done, intr_req,
           int_enter, cond_code,
    input  flags, cond_true, trap_take, intr_take
  );

  modport slave (
    input  alu_valid, alu_status, alu_mask, flag_op_valid, flag_op,
           load_valid, load_sel, load_data, instr_done, intr_req,
           int_enter, cond_code,
    output flags, cond_true, trap_take, intr_take
  );

endinterface

// File: rtl/flag_cond.sv
// Combinational Jcc evaluator: cond_code against a FLAGS word, no state.
// Odd codes are the complement of the preceding even code.
module flag_cond
  import flag_pkg::*;
(
  input  logic [3:0]           cond_code,
  input  logic [WORD_SIZE-1:0] flags,
  output logic                 cond_true
);

  logic base;
  logic unused_flag_bits;

  assign unused_flag_bits = ^{flags[15:12], flags[10:8], flags[5:3], flags[1]};

  always_comb begin
    base = 1'b0;
    unique case (cond_code)
      CC_O,  CC_NO: base = flags[FL_OF];
      CC_B,  CC_AE: base = flags[FL_CF];
      CC_E,  CC_NE: base = flags[FL_ZF];
      CC_BE, CC_A:  base = flags[FL_CF] | flags[FL_ZF];
      CC_S,  CC_NS: base = flags[FL_SF];
      CC_P,  CC_NP: base = flags[FL_PF];
      CC_L,  CC_GE: base = flags[FL_SF] ^ flags[FL_OF];
      CC_LE, CC_G:  base = flags[FL_ZF] | (flags[FL_SF] ^ flags[FL_OF]);
      default:      base = 1'b0;
    endcase
    cond_true = base ^ cond_code[0];
  end

endmodule

// File: rtl/flag_unit.sv
// 8086 FLAGS register plus instruction-boundary trap/interrupt sequencer.
// Writes land one cycle after their valid; trap_take/intr_take are one-cycle registered pulses.
module flag_unit
  import flag_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  flag_unit_if.slave  bus
);

  logic [WORD_SIZE-1:0] flags_q, flags_d;
  logic shadow_q, shadow_d;
  logic tf_start_q, tf_start_d;
  logic trap_take_q, trap_take_d;
  logic intr_take_q, intr_take_d;
  logic sti_exec;
  logic cond_true;
  logic unused_status;

  assign unused_status = ^{bus.alu_status[15:13], bus.alu_status[11:9], bus.alu_status[3:0]};

  // Sources applied lowest priority first so later ones override per bit.
  always_comb begin
    flags_d = flags_q;
    if (bus.alu_valid) begin
      if (bus.alu_mask[AM_CF]) flags_d[FL_CF] = bus.alu_status[ST_CF];
      if (bus.alu_mask[AM_PF]) flags_d[FL_PF] = bus.alu_status[ST_PF];
      if (bus.alu_mask[AM_AF]) flags_d[FL_AF] = bus.alu_status[ST_AF];
      if (bus.alu_mask[AM_ZF]) flags_d[FL_ZF] = bus.alu_status[ST_ZF];
      if (bus.alu_mask[AM_SF]) flags_d[FL_SF] = bus.alu_status[ST_SF];
      if (bus.alu_mask[AM_OF]) flags_d[FL_OF] = bus.alu_status[ST_OF];
    end
    if (bus.flag_op_valid) begin
      unique case (flag_op_e'(bus.flag_op))
        OP_NOP: ;
        OP_CLC: flags_d[FL_CF] = 1'b0;
        OP_STC: flags_d[FL_CF] = 1'b1;
        OP_CMC: flags_d[FL_CF] = ~flags_q[FL_CF];
        OP_CLD: flags_d[FL_DF] = 1'b0;
        OP_STD: flags_d[FL_DF] = 1'b1;
        OP_CLI: flags_d[FL_IF] = 1'b0;
        OP_STI: flags_d[FL_IF] = 1'b1;
        default: ;
      endcase
    end
    if (bus.load_valid) begin
      if (load_sel_e'(bus.load_sel) == LOAD_POPF) flags_d = bus.load_data & FLAGS_MASK;
      else                                       flags_d[7:0] = bus.load_data[7:0] & SAHF_MASK;
    end
    if (bus.int_enter) begin
      flags_d[FL_IF] = 1'b0;
      flags_d[FL_TF] = 1'b0;
    end
    flags_d = flags_d & FLAGS_MASK;
  end

  // Boundary decisions use pre-update register values only.
  always_comb begin
    sti_exec    = bus.flag_op_valid && (flag_op_e'(bus.flag_op) == OP_STI);
    trap_take_d = bus.instr_done & tf_start_q;
    intr_take_d = bus.instr_done & flags_q[FL_IF] & bus.intr_req & ~shadow_q & ~tf_start_q;
    tf_start_d  = bus.instr_done ? flags_q[FL_TF] : tf_start_q;
    shadow_d    = shadow_q;
    if (sti_exec)            shadow_d = 1'b1;
    else if (bus.instr_done) shadow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= '0;
      shadow_q    <= 1'b0;
      tf_start_q  <= 1'b0;
      trap_take_q <= 1'b0;
      intr_take_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      shadow_q    <= shadow_d;
      tf_start_q  <= tf_start_d;
      trap_take_q <= trap_take_d;
      intr_take_q <= intr_take_d;
    end
  end

  flag_cond u_cond (
    .cond_code (bus.cond_code),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

  assign bus.flags     = flags_q;
  assign bus.cond_true = cond_true;
  assign bus.trap_take = trap_take_q;
  assign bus.intr_take = intr_take_q;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: directed scenarios then randomized traffic against a
// behavioural model of the FLAGS rules and boundary sequencer.
module tb_flag_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;

  flag_unit_if bus();

  flag_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // model state
  logic [15:0] m_flags;
  bit          m_shadow, m_tf_start, m_trap, m_intr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0; m_shadow = 0; m_tf_start = 0; m_trap = 0; m_intr = 0;
  endtask

  // Jcc semantics written out per mnemonic
  function automatic logic cond_model(input logic [3:0] code, input logic [15:0] f);
    logic cf, pf, zf, sf, of_;
    cf = f[0]; pf = f[2]; zf = f[6]; sf = f[7]; of_ = f[11];
    case (code)
      4'h0: return of_;
      4'h1: return !of_;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return zf;
      4'h5: return !zf;
      4'h6: return cf || zf;
      4'h7: return !cf && !zf;
      4'h8: return sf;
      4'h9: return !sf;
      4'hA: return pf;
      4'hB: return !pf;
      4'hC: return sf != of_;
      4'hD: return sf == of_;
      4'hE: return zf || (sf != of_);
      default: return !zf && (sf == of_);
    endcase
  endfunction

  function automatic logic [15:0] model_next_flags();
    logic [15:0] f;
    int fpos [6];
    int spos [6];
    fpos = '{0, 2, 4, 6, 7, 11};
    spos = '{4, 5, 6, 7, 8, 12};
    f = m_flags;
    if (bus.alu_valid)
      for (int i = 0; i < 6; i++)
        if (bus.alu_mask[i]) f[fpos[i]] = bus.alu_status[spos[i]];
    if (bus.flag_op_valid)
      case (bus.flag_op)
        3'd1: f[0] = 1'b0;
        3'd2: f[0] = 1'b1;
        3'd3: f[0] = ~m_flags[0];
        3'd4: f[10] = 1'b0;
        3'd5: f[10] = 1'b1;
        3'd6: f[9] = 1'b0;
        3'd7: f[9] = 1'b1;
        default: ;
      endcase
    if (bus.load_valid) begin
      if (bus.load_sel == 1'b0) f = bus.load_data & 16'h0FD5;
      else                      f[7:0] = bus.load_data[7:0] & 8'hD5;
    end
    if (bus.int_enter) begin
      f[9] = 1'b0;
      f[8] = 1'b0;
    end
    return f;
  endfunction

  task automatic model_edge();
    logic [15:0] nf;
    nf = model_next_flags();
    m_trap = bus.instr_done && m_tf_start;
    m_intr = bus.instr_done && m_flags[9] && bus.intr_req && !m_shadow && !m_trap;
    if (bus.instr_done) m_tf_start = m_flags[8];
    if (bus.flag_op_valid && bus.flag_op == 3'd7) m_shadow = 1;
    else if (bus.instr_done)                      m_shadow = 0;
    m_flags = nf;
  endtask

  task automatic clear_pulses();
    bus.alu_valid = 0; bus.flag_op_valid = 0; bus.load_valid = 0;
    bus.instr_done = 0; bus.int_enter = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".flags"}, bus.flags, m_flags);
    check({tag, ".trap"}, {15'b0, bus.trap_take}, {15'b0, m_trap});
    check({tag, ".intr"}, {15'b0, bus.intr_take}, {15'b0, m_intr});
    check({tag, ".cond"}, {15'b0, bus.cond_true}, {15'b0, cond_model(bus.cond_code, m_flags)});
    clear_pulses();
  endtask

  task automatic popf(input logic [15:0] d);
    bus.load_valid = 1; bus.load_sel = 0; bus.load_data = d;
    step("popf");
  endtask

  task automatic cond_chk(input string tag, input logic [3:0] code, input logic exp);
    bus.cond_code = code;
    #1;
    check(tag, {15'b0, bus.cond_true}, {15'b0, exp});
    check({tag, ".mdl"}, {15'b0, bus.cond_true}, {15'b0, cond_model(code, m_flags)});
  endtask

  initial begin
    bit prev_done;
    clear_pulses();
    bus.alu_status = '0; bus.alu_mask = '0; bus.flag_op = '0; bus.load_sel = 0;
    bus.load_data = '0; bus.intr_req = 0; bus.cond_code = 4'h0;
    model_reset();

    #12;
    check("rst.flags", bus.flags, 16'h0000);
    check("rst.trap", {15'b0, bus.trap_take}, 16'h0000);
    check("rst.intr", {15'b0, bus.intr_take}, 16'h0000);
    #1 reset_n = 1;

    // ALU writes with masking
    bus.alu_valid = 1; bus.alu_status = 16'h1090; bus.alu_mask = 6'h3F;
    step("alu1");
    check("tp.alu1", bus.flags, 16'h0841);
    bus.alu_valid = 1; bus.alu_status = 16'h0000; bus.alu_mask = 6'h3E;
    step("alu2");
    check("tp.alu2", bus.flags, 16'h0001);

    // loads and CMC
    popf(16'hFFFF);
    check("tp.popf", bus.flags, 16'h0FD5);
    bus.load_valid = 1; bus.load_sel = 1; bus.load_data = 16'h0000;
    step("sahf");
    check("tp.sahf", bus.flags, 16'h0F00);
    bus.flag_op_valid = 1; bus.flag_op = 3'd3;
    step("cmc");
    check("tp.cmc", bus.flags, 16'h0F01);

    // same-cycle priority
    bus.load_valid = 1; bus.load_sel = 0; bus.load_data = 16'h0000;
    bus.flag_op_valid = 1; bus.flag_op = 3'd2; bus.int_enter = 1;
    step("prio");
    check("tp.prio", bus.flags, 16'h0000);

    // Jcc evaluation
    popf(16'h0080);
    cond_chk("cc.L", 4'hC, 1'b1);
    cond_chk("cc.GE", 4'hD, 1'b0);
    cond_chk("cc.LE", 4'hE, 1'b1);
    popf(16'h0040);
    cond_chk("cc.BE", 4'h6, 1'b1);
    cond_chk("cc.A", 4'h7, 1'b0);
    cond_chk("cc.E", 4'h4, 1'b1);

    // STI shadow defers interrupt by one boundary
    bus.intr_req = 1;
    popf(16'h0000);
    bus.flag_op_valid = 1; bus.flag_op = 3'd7;
    step("sti");
    bus.instr_done = 1;
    step("bnd1");
    check("tp.shadow", {15'b0, bus.intr_take}, 16'h0000);
    bus.instr_done = 1;
    step("bnd2");
    check("tp.intr", {15'b0, bus.intr_take}, 16'h0001);
    step("idle");
    check("tp.intr_1cyc", {15'b0, bus.intr_take}, 16'h0000);
    bus.intr_req = 0;

    // single-step trap, then async reset while the pulse is high
    popf(16'h0300);
    step("settle");
    bus.instr_done = 1;
    step("tbnd1");
    check("tp.notrap", {15'b0, bus.trap_take}, 16'h0000);
    bus.intr_req = 1; bus.instr_done = 1;
    step("tbnd2");
    check("tp.trap", {15'b0, bus.trap_take}, 16'h0001);
    check("tp.trap_only", {15'b0, bus.intr_take}, 16'h0000);
    #1 reset_n = 0;
    #1;
    model_reset();
    check("rst2.flags", bus.flags, 16'h0000);
    check("rst2.trap", {15'b0, bus.trap_take}, 16'h0000);
    check("rst2.intr", {15'b0, bus.intr_take}, 16'h0000);
    #1 reset_n = 1;
    bus.intr_req = 0; bus.instr_done = 1;
    step("post_rst");
    check("tp.tf_start_rst", {15'b0, bus.trap_take}, 16'h0000);

    // interrupt entry clears IF and TF
    popf(16'h0300);
    bus.int_enter = 1;
    step("intent");
    check("tp.int_enter", bus.flags, 16'h0000);

    // randomized traffic
    prev_done = 0;
    for (int n = 0; n < 2000; n++) begin
      bus.alu_valid     = 1'($urandom);
      bus.alu_status    = 16'($urandom);
      bus.alu_mask      = 6'($urandom);
      bus.flag_op_valid = ($urandom_range(0, 2) == 0);
      bus.flag_op       = 3'($urandom);
      bus.load_valid    = ($urandom_range(0, 4) == 0);
      bus.load_sel      = 1'($urandom);
      bus.load_data     = 16'($urandom);
      bus.int_enter     = ($urandom_range(0, 9) == 0);
      bus.cond_code     = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus.intr_req = ~bus.intr_req;
      bus.instr_done = !prev_done && ($urandom_range(0, 2) == 0) &&
                       !(bus.flag_op_valid && bus.flag_op == 3'd7);
      prev_done = bus.instr_done;
      step("rnd");
      check("rnd.excl", {15'b0, bus.trap_take & bus.intr_take}, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
